qk_score: RTL
=============

QK_SCORE -- requirements
Module: qk_score

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each signed two's-complement Q/K element.
REQ-002 Parameter L, default 8: sequence length.
REQ-003 Parameter N, default 1: batch size; T = L*N tokens.
REQ-004 Parameter E, default 8: embedding dimension.
REQ-005 Parameter OUT_WIDTH, default 32: width of each signed score element.
REQ-006 Parameter SHIFT, default 1: arithmetic right shift applied to each dot product as the 1/sqrt(E) scale.
REQ-007 clk  input  1  single clock; all logic on posedge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 start  input  1  run request; sampled only in S_IDLE.
REQ-010 Q_in  input  DATA_WIDTH*T*E  Q matrix (T,E); element (tok,d) at bits [(tok*E+d+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-011 K_in  input  DATA_WIDTH*T*E  K matrix, same packing as Q_in.
REQ-012 S_out  output  OUT_WIDTH*T*T  score matrix; element (i,j) at bits [(i*T+j+1)*OUT_WIDTH-1 -: OUT_WIDTH].
REQ-013 done  output  1  one-cycle pulse at run completion.
REQ-014 out_valid  output  1  high in the same cycle as done.

Function
REQ-015 S[i][j] = sat_OUT_WIDTH( (sum over d of Q[i][d]*K[j][d]) >>> SHIFT ), signed arithmetic throughout.
REQ-016 Products are 2*DATA_WIDTH bits; the accumulator is 2*DATA_WIDTH+clog2(E) bits wide and cannot overflow.
REQ-017 Shift: arithmetic, rounding toward minus infinity; saturation clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-018 FSM states: S_IDLE, S_LOAD, S_MAC, S_STORE, S_DONE.
REQ-019 S_IDLE -> S_LOAD when start=1; otherwise remain in S_IDLE.
REQ-020 S_LOAD: capture Q_in and K_in into internal registers, clear the accumulator and the i, j, d counters; then -> S_MAC.
REQ-021 S_MAC: each cycle, accumulate Q[i][d]*K[j][d] and increment d; when d=E-1 -> S_STORE.
REQ-022 S_STORE: write the scaled, saturated result to score[i][j], clear acc and d, advance j (wrapping to 0 with i+1); -> S_DONE after (T-1,T-1), else -> S_MAC.
REQ-023 S_DONE: copy score memory to S_out; done=out_valid=1 for exactly this cycle; -> S_IDLE.
REQ-024 Latency: if start is sampled at edge 0, S_DONE is entered at edge 1+T*T*(E+1).
REQ-025 start is ignored in every state other than S_IDLE; if start is held high, a new run begins on the cycle after S_DONE.
REQ-026 Q_in and K_in changes after S_LOAD do not affect the running computation.
REQ-027 S_out holds the previous run's result until the next S_DONE.

Reset
REQ-028 On rst_n=0: state=S_IDLE, S_out=0, done=0, out_valid=0, all counters, the accumulator and all internal Q/K/score storage cleared, at any time including mid-run.
REQ-029 After reset is released, the block accepts start on the first clock edge.

Structure
REQ-030 The state enum and a clog2-derived accumulator-width constant shall reside in the shared package attn_pkg.
REQ-031 One sub-module, mac_unit (signed DATA_WIDTH x DATA_WIDTH multiply-accumulate with synchronous clear and enable), shall hold the accumulator.
REQ-032 Only one multiplier is instantiated.

Verification (L=2, N=1, E=2 unless noted)
REQ-033 Q=[[1,2],[3,4]], K=[[1,0],[0,1]], SHIFT=1 -> S_out=[[0,1],[1,2]]; done pulse exactly at edge 13 after the start edge.
REQ-034 Q=[[-3,0],[0,0]], K=[[1,0],[0,0]], SHIFT=1 -> S[0][0]=-2; all other elements 0.
REQ-035 OUT_WIDTH=16, all Q=K=0x7FFF -> every S=0x7FFF; all Q=0x8000, K=0x7FFF -> every S=0x8000.
REQ-036 start held high for 40 cycles -> back-to-back runs, each with a single-cycle done; a start pulse mid-run is ignored.
REQ-037 rst_n asserted during S_MAC -> all outputs 0 immediately; a subsequent run with the REQ-033 data gives the REQ-033 result.
REQ-038 Q_in changed to all-zero one cycle after S_LOAD -> result still equals the REQ-033 values.

Source files
------------

// File: rtl/attn_pkg.sv
// rtl/attn_pkg.sv - shared FSM state type and accumulator sizing for the score engine
package attn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_STORE,
        S_DONE
    } state_t;

    // Sum of E products of two DATA_WIDTH operands never overflows at this width.
    function automatic int acc_width(input int data_width, input int e);
        return 2 * data_width + $clog2(e);
    endfunction

    localparam int ACC_W_DEFAULT = acc_width(16, 8);

endpackage

// File: rtl/qk_score_if.sv
// rtl/qk_score_if.sv - run request, Q/K operand and score result bundle
interface qk_score_if #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8,
    parameter int OUT_WIDTH  = 32
);
    localparam int T = L * N;

    logic                          start;
    logic [DATA_WIDTH*T*E-1:0]     Q_in;
    logic [DATA_WIDTH*T*E-1:0]     K_in;
    logic [OUT_WIDTH*T*T-1:0]      S_out;
    logic                          done;
    logic                          out_valid;

    modport master (output start, Q_in, K_in, input S_out, done, out_valid);
    modport slave  (input start, Q_in, K_in, output S_out, done, out_valid);

endinterface

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply-accumulate with synchronous clear and enable
module mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_W      = 35
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_W-1:0]      acc
);
    logic signed [2*DATA_WIDTH-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/qk_score.sv
// rtl/qk_score.sv - sequential Q*K^T score matrix with scale shift and saturation
module qk_score
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int SHIFT      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    qk_score_if.slave    bus
);
    localparam int T     = L * N;
    localparam int ACC_W = acc_width(DATA_WIDTH, E);
    localparam int SW    = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
    localparam int IW    = (T > 1) ? $clog2(T) : 1;
    localparam int DW_C  = (E > 1) ? $clog2(E) : 1;

    localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    state_t state, state_nxt;

    logic [DATA_WIDTH*T*E-1:0] q_reg, k_reg;
    logic [OUT_WIDTH*T*T-1:0]  score_mem, out_reg;
    logic [IW-1:0]             i_cnt, j_cnt;
    logic [DW_C-1:0]           d_cnt;

    logic signed [DATA_WIDTH-1:0] mac_a, mac_b;
    logic signed [ACC_W-1:0]      acc, acc_sh;
    logic signed [SW-1:0]         acc_ext;
    logic [OUT_WIDTH-1:0]         sat_val;
    logic                         last_d, last_elem;

    assign last_d    = (d_cnt == DW_C'(E - 1));
    assign last_elem = (i_cnt == IW'(T - 1)) && (j_cnt == IW'(T - 1));

    assign mac_a = q_reg[(int'(i_cnt) * E + int'(d_cnt)) * DATA_WIDTH +: DATA_WIDTH];
    assign mac_b = k_reg[(int'(j_cnt) * E + int'(d_cnt)) * DATA_WIDTH +: DATA_WIDTH];

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_W      (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state == S_LOAD) || (state == S_STORE)),
        .en    (state == S_MAC),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (acc)
    );

    // Arithmetic shift floors toward minus infinity; widen before clamping.
    always_comb begin
        acc_sh  = acc >>> SHIFT;
        acc_ext = SW'(acc_sh);
        sat_val = OUT_WIDTH'(acc_ext);
        if (acc_ext > MAXV) begin
            sat_val = OUT_WIDTH'(MAXV);
        end else if (acc_ext < MINV) begin
            sat_val = OUT_WIDTH'(MINV);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_MAC;
            S_MAC:   if (last_d) state_nxt = S_STORE;
            S_STORE: state_nxt = last_elem ? S_DONE : S_MAC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg     <= '0;
            k_reg     <= '0;
            score_mem <= '0;
            out_reg   <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            d_cnt     <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    q_reg <= bus.Q_in;
                    k_reg <= bus.K_in;
                    i_cnt <= '0;
                    j_cnt <= '0;
                    d_cnt <= '0;
                end
                S_MAC: begin
                    d_cnt <= last_d ? '0 : d_cnt + 1'b1;
                end
                S_STORE: begin
                    score_mem[(int'(i_cnt) * T + int'(j_cnt)) * OUT_WIDTH +: OUT_WIDTH] <= sat_val;
                    d_cnt <= '0;
                    if (j_cnt == IW'(T - 1)) begin
                        j_cnt <= '0;
                        i_cnt <= i_cnt + 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    out_reg <= score_mem;
                end
                default: ;
            endcase
        end
    end

    // Fresh scores are visible during the done cycle, then held in out_reg.
    assign bus.S_out     = (state == S_DONE) ? score_mem : out_reg;
    assign bus.done      = (state == S_DONE);
    assign bus.out_valid = (state == S_DONE);

endmodule
